// File: rtl/color_fader_if.sv
// Bundle between the FFT energy stage, the color fader and the display/LED driver.
// The energy side drives target/done/freeze; the fader drives the smoothed color and status.
interface color_fader_if;
    logic [83:0] target;
    logic        done;
    logic        freeze;
    logic [83:0] color_out;
    logic        frame_strobe;
    logic        busy;
    logic        settled;

    modport master (
        output target,
        output done,
        output freeze,
        input  color_out,
        input  frame_strobe,
        input  busy,
        input  settled
    );

    modport slave (
        input  target,
        input  done,
        input  freeze,
        output color_out,
        output frame_strobe,
        output busy,
        output settled
    );
endinterface

// File: rtl/color_fader.sv
// Smooths the 21-nibble RGB444 bin color word toward the last captured target, one nibble per cycle per tick.
// Define COLOR_FADER_INSTANT_EN to jump straight to the captured color on each tick instead of fading.
module color_fader #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int STEP        = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    color_fader_if.slave bus
);

    localparam int             CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [4:0]     LAST_IDX  = 5'd20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SWEEP,
        S_STROBE
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          done_q;
    logic          capture;

    logic [83:0]   target_hold;
    logic [83:0]   snap;
    logic [83:0]   work;
    logic [83:0]   color_q;
    logic [4:0]    idx;
    logic          chg;
    logic          strobe_q;
    logic          settled_q;
    logic          busy;

    logic          load_snap;
    logic          do_step;
    logic          publish;

    logic [6:0]    nib_lsb;
    logic [3:0]    snap_nib;
    logic [3:0]    work_nib;
    logic [3:0]    next_nib;

    assign tick    = (tick_cnt == TICK_LAST);
    assign capture = bus.done & ~done_q & ~bus.freeze;
    assign busy    = (state_q == S_SWEEP) || (state_q == S_STROBE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Captures are independent of the fade FSM so a new frame is never lost mid-sweep.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q      <= 1'b0;
            target_hold <= '0;
        end else begin
            done_q <= bus.done;
            if (capture) begin
                target_hold <= bus.target;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_snap = 1'b0;
        do_step   = 1'b0;
        publish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick) begin
                    load_snap = 1'b1;
                    state_d   = S_SWEEP;
                end
            end
            S_SWEEP: begin
                do_step = 1'b1;
                if (idx == LAST_IDX) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                publish = 1'b1;
                state_d = S_WAIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign nib_lsb  = {idx, 2'b00};
    assign snap_nib = snap[nib_lsb +: 4];
    assign work_nib = work[nib_lsb +: 4];

`ifdef COLOR_FADER_INSTANT_EN
    assign next_nib = snap_nib;
`else
    localparam logic [3:0] STEP_N = 4'(STEP);

    logic [3:0] diff;
    logic [3:0] step_amt;

    // Clamping the step to the remaining distance keeps the nibble from overshooting or wrapping.
    always_comb begin
        diff     = '0;
        step_amt = '0;
        next_nib = work_nib;
        if (snap_nib > work_nib) begin
            diff     = snap_nib - work_nib;
            step_amt = (diff < STEP_N) ? diff : STEP_N;
            next_nib = work_nib + step_amt;
        end else if (snap_nib < work_nib) begin
            diff     = work_nib - snap_nib;
            step_amt = (diff < STEP_N) ? diff : STEP_N;
            next_nib = work_nib - step_amt;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap     <= '0;
            work     <= '0;
            color_q  <= '0;
            idx      <= '0;
            chg      <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (load_snap) begin
                snap <= target_hold;
                idx  <= '0;
                chg  <= 1'b0;
            end
            if (do_step) begin
                work[nib_lsb +: 4] <= next_nib;
                idx                <= idx + 5'd1;
                if (snap_nib != work_nib) begin
                    chg <= 1'b1;
                end
            end
            // The whole word is published in one edge so the driver never sees a half-updated frame.
            if (publish) begin
                color_q  <= work;
                strobe_q <= chg;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            settled_q <= 1'b1;
        end else begin
            settled_q <= (color_q == target_hold) && !busy;
        end
    end

    assign bus.color_out    = color_q;
    assign bus.frame_strobe = strobe_q;
    assign bus.busy         = busy;
    assign bus.settled      = settled_q;

endmodule

// File: tb/tb_color_fader.sv
// Directed bench for color_fader: instance A uses STEP=1, instance B uses STEP=4, both with 32-cycle ticks.
// With COLOR_FADER_INSTANT_EN defined, the single-tick jump behaviour is exercised instead of the fades.
module tb_color_fader;

    logic clock;
    logic reset_n;

    color_fader_if bus_a ();
    color_fader_if bus_b ();

    color_fader #(.TICK_CYCLES(32), .STEP(1)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    color_fader #(.TICK_CYCLES(32), .STEP(4)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    int          assertions;
    int          failures;
    int          n;
    int          lat;
    logic        seen;
    logic [3:0]  nib;
    logic [3:0]  up_seq   [3] = '{4'h4, 4'h8, 4'hA};
    logic [3:0]  down_seq [3] = '{4'h6, 4'h2, 4'h1};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [83:0] obs, input logic [83:0] exp);
        assertions++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    function automatic logic tickOf(input bit sel);
        return sel ? dut_b.tick : dut_a.tick;
    endfunction

    function automatic logic strobeOf(input bit sel);
        return sel ? bus_b.frame_strobe : bus_a.frame_strobe;
    endfunction

    task automatic applyStimulus(input bit sel, input logic [83:0] tgt);
        if (tickOf(sel)) @(negedge clock);
        if (sel) begin
            bus_b.target = tgt;
            bus_b.done   = 1'b1;
        end else begin
            bus_a.target = tgt;
            bus_a.done   = 1'b1;
        end
        @(negedge clock);
        if (sel) bus_b.done = 1'b0;
        else     bus_a.done = 1'b0;
    endtask

    task automatic waitTick(input bit sel, output int cnt);
        cnt = 0;
        while (!tickOf(sel) && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    task automatic waitStrobe(input bit sel, output int cnt);
        cnt = 0;
        while (!strobeOf(sel) && cnt < 60) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    initial begin
        assertions   = 0;
        failures     = 0;
        bus_a.target = '0;
        bus_a.done   = 1'b0;
        bus_a.freeze = 1'b0;
        bus_b.target = '0;
        bus_b.done   = 1'b0;
        bus_b.freeze = 1'b0;
        reset_n      = 1'b0;

        repeat (4) @(negedge clock);
        checkOutput("reset_color",   bus_a.color_out,          84'(0));
        checkOutput("reset_strobe",  84'(bus_a.frame_strobe),  84'(0));
        checkOutput("reset_busy",    84'(bus_a.busy),          84'(0));
        checkOutput("reset_settled", 84'(bus_a.settled),       84'(1));
        checkOutput("reset_color_b", bus_b.color_out,          84'(0));

        reset_n = 1'b1;
        waitTick(0, n);
        checkOutput("first_tick_cycle", 84'(n), 84'(31));
        seen = 1'b0;
        repeat (25) begin
            @(negedge clock);
            seen |= bus_a.frame_strobe;
        end
        checkOutput("no_strobe_first_tick", 84'(seen), 84'(0));

`ifdef COLOR_FADER_INSTANT_EN
        applyStimulus(0, {21{4'hF}});
        waitTick(0, n);
        waitStrobe(0, lat);
        checkOutput("instant_latency", 84'(lat), 84'(23));
        checkOutput("instant_color", bus_a.color_out, {21{4'hF}});
        waitTick(0, n);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            seen |= bus_a.frame_strobe;
        end
        checkOutput("instant_no_second_strobe", 84'(seen), 84'(0));
        checkOutput("instant_settled", 84'(bus_a.settled), 84'(1));
        checkOutput("instant_color_held", bus_a.color_out, {21{4'hF}});
`else
        // Full ramp 0 -> F with STEP=1: fifteen strobes, one count per strobe.
        applyStimulus(0, {21{4'hF}});
        for (int i = 1; i <= 15; i++) begin
            waitTick(0, n);
            waitStrobe(0, lat);
            checkOutput($sformatf("ramp%0d_latency", i), 84'(lat), 84'(23));
            nib = 4'(i);
            checkOutput($sformatf("ramp%0d_color", i), bus_a.color_out, {21{nib}});
            @(negedge clock);
            checkOutput($sformatf("ramp%0d_strobe_width", i), 84'(bus_a.frame_strobe), 84'(0));
            if (i == 1) checkOutput("ramp_settled_low", 84'(bus_a.settled), 84'(0));
        end
        repeat (2) @(negedge clock);
        checkOutput("ramp_settled_high", 84'(bus_a.settled), 84'(1));
        waitTick(0, n);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            seen |= bus_a.frame_strobe;
        end
        checkOutput("ramp_16th_tick_no_strobe", 84'(seen), 84'(0));

        // STEP=4 up and down sequences.
        applyStimulus(1, {21{4'hA}});
        for (int k = 0; k < 3; k++) begin
            waitTick(1, n);
            waitStrobe(1, lat);
            checkOutput($sformatf("step4_up%0d_latency", k), 84'(lat), 84'(23));
            nib = up_seq[k];
            checkOutput($sformatf("step4_up%0d_color", k), bus_b.color_out, {21{nib}});
        end
        applyStimulus(1, {21{4'h1}});
        for (int k = 0; k < 3; k++) begin
            waitTick(1, n);
            waitStrobe(1, lat);
            nib = down_seq[k];
            checkOutput($sformatf("step4_down%0d_color", k), bus_b.color_out, {21{nib}});
        end
        repeat (2) @(negedge clock);
        checkOutput("step4_settled", 84'(bus_b.settled), 84'(1));

        // Freeze blocks the capture; fading state stays put.
        bus_a.freeze = 1'b1;
        applyStimulus(0, 84'(0));
        checkOutput("freeze_hold_kept", dut_a.target_hold, {21{4'hF}});
        waitTick(0, n);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            seen |= bus_a.frame_strobe;
        end
        checkOutput("freeze_no_strobe", 84'(seen), 84'(0));
        checkOutput("freeze_color", bus_a.color_out, {21{4'hF}});
        bus_a.freeze = 1'b0;
        applyStimulus(0, 84'(0));
        checkOutput("unfreeze_capture", dut_a.target_hold, 84'(0));
        waitTick(0, n);
        waitStrobe(0, lat);
        checkOutput("unfreeze_color", bus_a.color_out, {21{4'hE}});

        // Capture during SWEEP: current strobe uses the old snap, next tick uses the new target.
        waitTick(0, n);
        repeat (5) @(negedge clock);
        applyStimulus(0, {21{4'hF}});
        waitStrobe(0, lat);
        checkOutput("midsweep_old_snap", bus_a.color_out, {21{4'hD}});
        waitTick(0, n);
        waitStrobe(0, lat);
        checkOutput("midsweep_new_target", bus_a.color_out, {21{4'hE}});

        // Reset in the middle of a sweep.
        waitTick(0, n);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_color",   bus_a.color_out,         84'(0));
        checkOutput("midreset_strobe",  84'(bus_a.frame_strobe), 84'(0));
        checkOutput("midreset_busy",    84'(bus_a.busy),         84'(0));
        checkOutput("midreset_settled", 84'(bus_a.settled),      84'(1));
        checkOutput("midreset_state",   84'(dut_a.state_q),      84'(0));
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (45) begin
            @(negedge clock);
            seen |= bus_a.frame_strobe | bus_b.frame_strobe;
        end
        checkOutput("midreset_no_strobe", 84'(seen), 84'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
